riscv_vector_wb_scheduler: RTL and testbench

//  Schedules writebacks from NUM_REQ vector/crypto functional units (AES, SHA, load) onto the two

---
 rtl/riscv_vector_wb_scheduler.sv | 139 +++++++++++++
 tb/tb_riscv_vector_wb_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_vector_wb_scheduler.sv
// Vector RF writeback scheduler: grants up to two requesters per cycle onto write ports A/B
// and tracks pending destination registers. Define VWB_FIXED_PRIO_EN for fixed priority.
module riscv_vector_wb_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int VADDR_WIDTH = 6,
    parameter int VDATA_WIDTH = 256
) (
    input  logic                           clk_int,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*VADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*VDATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic                           iss_valid_i,
    input  logic [VADDR_WIDTH-1:0]         iss_vd_i,
    output logic                           iss_ready_o,
    input  logic [3*VADDR_WIDTH-1:0]       chk_addr_i,
    output logic [2:0]                     chk_busy_o,
    output logic [VADDR_WIDTH-1:0]         vwaddr_a_o,
    output logic [VDATA_WIDTH-1:0]         vwdata_a_o,
    output logic                           vwe_a_o,
    output logic [VADDR_WIDTH-1:0]         vwaddr_b_o,
    output logic [VDATA_WIDTH-1:0]         vwdata_b_o,
    output logic                           vwe_b_o,
    output logic [31:0]                    busy_o
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr;
    logic          g0_found, g1_found;
    logic [PW-1:0] g0_idx, g1_idx, last_idx;
    logic [4:0]    g0_reg, g1_reg;
    logic [31:0]   busy, clr_mask, set_mask;
    int            idx;

    // Only bits [4:0] of any register address select one of the 32 registers.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iss_vd_i[VADDR_WIDTH-1:5],
                                chk_addr_i[3*VADDR_WIDTH-1:2*VADDR_WIDTH+5],
                                chk_addr_i[2*VADDR_WIDTH-1:VADDR_WIDTH+5],
                                chk_addr_i[VADDR_WIDTH-1:5]};

    // G0 is the first valid requester from ptr upward; G1 the next one writing a different register.
    always_comb begin
        g0_found = 1'b0;
        g1_found = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        g0_reg   = '0;
        g1_reg   = '0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req_valid_i[idx]) begin
                if (!g0_found) begin
                    g0_found = 1'b1;
                    g0_idx   = PW'(idx);
                    g0_reg   = req_addr_i[idx*VADDR_WIDTH +: 5];
                end else if (!g1_found && (req_addr_i[idx*VADDR_WIDTH +: 5] != g0_reg)) begin
                    g1_found = 1'b1;
                    g1_idx   = PW'(idx);
                    g1_reg   = req_addr_i[idx*VADDR_WIDTH +: 5];
                end
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (g0_found) req_ready_o[g0_idx] = 1'b1;
        if (g1_found) req_ready_o[g1_idx] = 1'b1;
        req_ready_o = req_ready_o & {NUM_REQ{rst_n}};
    end

    assign last_idx = g1_found ? g1_idx : g0_idx;

`ifdef VWB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (g0_found) begin
            ptr <= (int'(last_idx) == NUM_REQ - 1) ? '0 : last_idx + 1'b1;
        end
    end
`endif

    // A register written back this cycle may be re-reserved in the same cycle.
    always_comb begin
        clr_mask = '0;
        if (g0_found) clr_mask[g0_reg] = 1'b1;
        if (g1_found) clr_mask[g1_reg] = 1'b1;
    end

    assign iss_ready_o = ~busy[iss_vd_i[4:0]] | clr_mask[iss_vd_i[4:0]];

    always_comb begin
        set_mask = '0;
        if (iss_valid_i && iss_ready_o) set_mask[iss_vd_i[4:0]] = 1'b1;
    end

    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    assign busy_o        = busy;
    assign chk_busy_o[0] = busy[chk_addr_i[4:0]];
    assign chk_busy_o[1] = busy[chk_addr_i[VADDR_WIDTH +: 5]];
    assign chk_busy_o[2] = busy[chk_addr_i[2*VADDR_WIDTH +: 5]];

    // Write stage: address/data hold their last value while the port is idle.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            vwe_a_o    <= 1'b0;
            vwaddr_a_o <= '0;
            vwdata_a_o <= '0;
            vwe_b_o    <= 1'b0;
            vwaddr_b_o <= '0;
            vwdata_b_o <= '0;
        end else begin
            vwe_a_o <= g0_found;
            vwe_b_o <= g1_found;
            if (g0_found) begin
                vwaddr_a_o <= req_addr_i[int'(g0_idx)*VADDR_WIDTH +: VADDR_WIDTH];
                vwdata_a_o <= req_data_i[int'(g0_idx)*VDATA_WIDTH +: VDATA_WIDTH];
            end
            if (g1_found) begin
                vwaddr_b_o <= req_addr_i[int'(g1_idx)*VADDR_WIDTH +: VADDR_WIDTH];
                vwdata_b_o <= req_data_i[int'(g1_idx)*VDATA_WIDTH +: VDATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_riscv_vector_wb_scheduler.sv
// Directed bench for riscv_vector_wb_scheduler: per-cycle model comparison plus literal checks.
module tb_riscv_vector_wb_scheduler;
    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 256;

    logic            clk_int;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            iss_valid;
    logic [AW-1:0]   iss_vd;
    logic            iss_ready;
    logic [3*AW-1:0] chk_addr;
    logic [2:0]      chk_busy;
    logic [AW-1:0]   vwaddr_a, vwaddr_b;
    logic [DW-1:0]   vwdata_a, vwdata_b;
    logic            vwe_a, vwe_b;
    logic [31:0]     busy;

    int n_checks = 0;
    int n_fails  = 0;

    riscv_vector_wb_scheduler #(.NUM_REQ(N), .VADDR_WIDTH(AW), .VDATA_WIDTH(DW)) dut (
        .clk_int(clk_int), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
        .req_ready_o(req_ready),
        .iss_valid_i(iss_valid), .iss_vd_i(iss_vd), .iss_ready_o(iss_ready),
        .chk_addr_i(chk_addr), .chk_busy_o(chk_busy),
        .vwaddr_a_o(vwaddr_a), .vwdata_a_o(vwdata_a), .vwe_a_o(vwe_a),
        .vwaddr_b_o(vwaddr_b), .vwdata_b_o(vwdata_b), .vwe_b_o(vwe_b),
        .busy_o(busy)
    );

    initial begin
        clk_int = 1'b0;
        forever #5 clk_int = ~clk_int;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0]     m_busy;
    int            m_p;
    bit            m_vwe_a, m_vwe_b;
    logic [AW-1:0] m_addr_a, m_addr_b;
    logic [DW-1:0] m_data_a, m_data_b;

    function automatic logic [4:0] reg_of(input int i);
        logic [AW-1:0] a;
        a = req_addr[i*AW +: AW];
        return a[4:0];
    endfunction

    always @(negedge clk_int) begin
        int order[$];
        int g0, g1;
        bit [31:0] cleared;
        bit [N-1:0] exp_ready;
        bit exp_iss;
        logic [4:0] vd;
        if (!rst_n) begin
            m_busy = '0; m_p = 0; m_vwe_a = 0; m_vwe_b = 0;
            m_addr_a = '0; m_addr_b = '0; m_data_a = '0; m_data_b = '0;
            check("rst_vwe_a", vwe_a, 0);
            check("rst_vwe_b", vwe_b, 0);
            check("rst_busy", busy, 0);
            check("rst_ready", req_ready, 0);
            check("rst_vwaddr_a", vwaddr_a, 0);
            check("rst_vwdata_b", vwdata_b, 0);
        end else begin
            check("vwe_a", vwe_a, m_vwe_a);
            check("vwe_b", vwe_b, m_vwe_b);
            check("vwaddr_a", vwaddr_a, m_addr_a);
            check("vwdata_a", vwdata_a, m_data_a);
            check("vwaddr_b", vwaddr_b, m_addr_b);
            check("vwdata_b", vwdata_b, m_data_b);
            check("busy", busy, m_busy);
            check("chk_busy", chk_busy, {m_busy[chk_addr[2*AW +: 5]], m_busy[chk_addr[AW +: 5]],
                                         m_busy[chk_addr[4:0]]});
            // valid requesters in priority order, then pick the first two distinct registers
            order = {};
            for (int k = 0; k < N; k++)
                if (req_valid[(m_p + k) % N]) order.push_back((m_p + k) % N);
            g0 = -1; g1 = -1;
            if (order.size() > 0) g0 = order[0];
            for (int i = 1; i < order.size(); i++)
                if (g1 < 0 && reg_of(order[i]) != reg_of(g0)) g1 = order[i];
            exp_ready = '0;
            cleared   = '0;
            if (g0 >= 0) begin exp_ready[g0] = 1; cleared[reg_of(g0)] = 1; end
            if (g1 >= 0) begin exp_ready[g1] = 1; cleared[reg_of(g1)] = 1; end
            check("req_ready", req_ready, exp_ready);
            vd = iss_vd[4:0];
            exp_iss = !m_busy[vd] || cleared[vd];
            check("iss_ready", iss_ready, exp_iss);
            // next state
            m_vwe_a = (g0 >= 0);
            m_vwe_b = (g1 >= 0);
            if (g0 >= 0) begin m_addr_a = req_addr[g0*AW +: AW]; m_data_a = req_data[g0*DW +: DW]; end
            if (g1 >= 0) begin m_addr_b = req_addr[g1*AW +: AW]; m_data_b = req_data[g1*DW +: DW]; end
            m_busy = m_busy & ~cleared;
            if (iss_valid && exp_iss) m_busy[vd] = 1;
`ifdef VWB_FIXED_PRIO_EN
            m_p = 0;
`else
            if (g0 >= 0) m_p = ((g1 >= 0 ? g1 : g0) + 1) % N;
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_int);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]       = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic mid();
        @(negedge clk_int);
        #1;
    endtask

    logic [N-1:0] exp_pairs [4];

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        iss_valid = 1'b0;
        iss_vd    = '0;
        chk_addr  = {6'd9, 6'd5, 6'd4};
        repeat (2) tick();
        check("reset_vwe_a", vwe_a, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;

        // 1: single requester
        tick();
        set_req(0, 6'd5, 256'hA5);
        mid();  check("t1_ready", req_ready, 4'b0001);
        tick(); req_valid = '0;
        check("t1_vwe_a", vwe_a, 1);
        check("t1_vwaddr_a", vwaddr_a, 5);
        check("t1_vwdata_a", vwdata_a, 256'hA5);
        check("t1_vwe_b", vwe_b, 0);

        // 2: two requesters, both ports
        set_req(1, 6'd3, 256'h33);
        set_req(2, 6'd7, 256'h77);
        mid();  check("t2_ready", req_ready, 4'b0110);
        tick(); req_valid = '0;
        check("t2_vwaddr_a", vwaddr_a, 3);
        check("t2_vwaddr_b", vwaddr_b, 7);
        check("t2_vwe_b", vwe_b, 1);

        // 3: same destination, second one deferred
        set_req(0, 6'd9, 256'h1);
        set_req(1, 6'd9, 256'h2);
        mid();  check("t3_ready0", req_ready, 4'b0001);
        tick(); req_valid[0] = 1'b0;
        check("t3_vwe_b", vwe_b, 0);
        check("t3_vwdata_a", vwdata_a, 256'h1);
        mid();  check("t3_ready1", req_ready, 4'b0010);
        tick(); req_valid = '0;
        check("t3_vwe_a2", vwe_a, 1);
        check("t3_vwdata_a2", vwdata_a, 256'h2);

        // 4: WAW stall on vd=4 released by the writeback grant
        iss_valid = 1'b1;
        iss_vd    = 6'd4;
        mid();  check("t4_iss_first", iss_ready, 1);
        tick();
        mid();  check("t4_iss_stall", iss_ready, 0);
        check("t4_chk_busy", chk_busy, 3'b001);
        tick();
        mid();  check("t4_iss_stall2", iss_ready, 0);
        tick();
        set_req(2, 6'd4, 256'h44);
        mid();  check("t4_iss_release", iss_ready, 1);
        check("t4_ready", req_ready, 4'b0100);
        tick(); req_valid = '0; iss_valid = 1'b0;
        check("t4_busy4", busy[4], 1);
        check("t4_vwaddr_a", vwaddr_a, 4);

        // realign pointer to 0 by granting requester 3
        set_req(3, 6'd30, 256'h3E);
        tick(); req_valid = '0;

        // 5: all four valid, distinct addresses
`ifdef VWB_FIXED_PRIO_EN
        exp_pairs = '{4'b0011, 4'b0011, 4'b0011, 4'b0011};
`else
        exp_pairs = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
`endif
        for (int i = 0; i < N; i++) set_req(i, AW'(10 + i), DW'(256'h100 + i));
        for (int c = 0; c < 4; c++) begin
            mid();  check("t5_pair", req_ready, exp_pairs[c]);
            tick();
        end
        req_valid = '0;

        // 6: asynchronous reset with a write in flight
        set_req(0, 6'd20, 256'hBEEF);
        mid();
        tick(); req_valid = '0;
        check("t6_vwe_a_pre", vwe_a, 1);
        check("t6_busy4_pre", busy[4], 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_vwe_a_async", vwe_a, 0);
        check("t6_vwe_b_async", vwe_b, 0);
        check("t6_busy_async", busy, 0);
        mid();
        tick(); rst_n = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
